// File: rtl/hpram_cmd_arbiter_if.sv
// Signal bundle between the frame-buffer DMA requesters, the HyperRAM command port
// and the arbiter status outputs. The arbiter uses 'master'; the surrounding logic uses 'slave'.
interface hpram_cmd_arbiter_if #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;

    logic                  I_init_calib;
    logic                  I_wr_req;
    logic [ADDR_WIDTH-1:0] I_wr_addr;
    logic [DATA_WIDTH-1:0] I_wr_data;
    logic [MASK_WIDTH-1:0] I_wr_mask;
    logic                  O_wr_ack;
    logic                  O_wr_data_rd;
    logic                  I_rd_req;
    logic [ADDR_WIDTH-1:0] I_rd_addr;
    logic                  O_rd_ack;
    logic                  O_rd_data_valid;
    logic [DATA_WIDTH-1:0] O_rd_data;
    logic                  O_cmd;
    logic                  O_cmd_en;
    logic [ADDR_WIDTH-1:0] O_addr;
    logic [DATA_WIDTH-1:0] O_wr_data;
    logic [MASK_WIDTH-1:0] O_data_mask;
    logic                  I_rd_data_valid;
    logic [DATA_WIDTH-1:0] I_rd_data;
    logic                  O_busy;
    logic                  O_err;
    logic [7:0]            O_err_cnt;

    modport master (
        input  I_init_calib, I_wr_req, I_wr_addr, I_wr_data, I_wr_mask,
               I_rd_req, I_rd_addr, I_rd_data_valid, I_rd_data,
        output O_wr_ack, O_wr_data_rd, O_rd_ack, O_rd_data_valid, O_rd_data,
               O_cmd, O_cmd_en, O_addr, O_wr_data, O_data_mask,
               O_busy, O_err, O_err_cnt
    );

    modport slave (
        output I_init_calib, I_wr_req, I_wr_addr, I_wr_data, I_wr_mask,
               I_rd_req, I_rd_addr, I_rd_data_valid, I_rd_data,
        input  O_wr_ack, O_wr_data_rd, O_rd_ack, O_rd_data_valid, O_rd_data,
               O_cmd, O_cmd_en, O_addr, O_wr_data, O_data_mask,
               O_busy, O_err, O_err_cnt
    );
endinterface

// File: rtl/hpram_cmd_arbiter.sv
// Round-robin arbiter of the single HyperRAM command port between the write and read DMAs:
// fixed-length bursts, write-beat pacing, read-beat counting, command gap and read timeout.
module hpram_cmd_arbiter #(
    parameter int ADDR_WIDTH = 22,
    parameter int DATA_WIDTH = 32,
    parameter int BURST      = 16,
    parameter int CMD_GAP    = 8,
    parameter int TIMEOUT    = 255
) (
    input  logic                I_clk,
    input  logic                I_rst_n,
    hpram_cmd_arbiter_if.master bus
);
    localparam int MASK_WIDTH = DATA_WIDTH / 8;
    localparam int BEAT_W     = $clog2(BURST);
    localparam int GAP_W      = (CMD_GAP > 1) ? $clog2(CMD_GAP) : 1;
    localparam int TO_W       = $clog2(TIMEOUT + 1);

    localparam logic [1:0] ST_IDLE     = 2'd0;
    localparam logic [1:0] ST_WR_BURST = 2'd1;
    localparam logic [1:0] ST_RD_WAIT  = 2'd2;
    localparam logic [1:0] ST_GAP      = 2'd3;

    logic [1:0]            state_reg, state_next;
    logic [BEAT_W-1:0]     beat_cnt_reg, beat_cnt_next;
    logic [GAP_W-1:0]      gap_cnt_reg, gap_cnt_next;
    logic [TO_W-1:0]       to_cnt_reg, to_cnt_next;
    logic                  last_grant_reg, last_grant_next;   // 1 = write granted last
    logic                  cmd_reg, cmd_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic                  cmd_en_reg, cmd_en_next;
    logic                  wr_ack_reg, wr_ack_next;
    logic                  rd_ack_reg, rd_ack_next;
    logic [7:0]            err_cnt_reg, err_cnt_next;
    logic                  err_pulse;

    logic                  calib;
    logic                  grant_wr;
    logic                  grant_rd;
    logic                  wr_phase;
    logic                  rd_phase;
    logic                  rd_last;
    logic                  to_expired;

    assign calib      = bus.I_init_calib;
    assign wr_phase   = (state_reg == ST_WR_BURST);
    assign rd_phase   = (state_reg == ST_RD_WAIT);
    assign rd_last    = bus.I_rd_data_valid && (beat_cnt_reg == BEAT_W'(BURST - 1));
    assign to_expired = (to_cnt_reg == TO_W'(TIMEOUT));

    // On a tie the requester that did not win last time gets the port.
    assign grant_wr = calib && bus.I_wr_req && (!bus.I_rd_req || !last_grant_reg);
    assign grant_rd = calib && bus.I_rd_req && (!bus.I_wr_req ||  last_grant_reg);

    always_comb begin
        state_next      = state_reg;
        beat_cnt_next   = beat_cnt_reg;
        gap_cnt_next    = gap_cnt_reg;
        to_cnt_next     = to_cnt_reg;
        last_grant_next = last_grant_reg;
        cmd_next        = cmd_reg;
        addr_next       = addr_reg;
        err_cnt_next    = err_cnt_reg;
        cmd_en_next     = 1'b0;
        wr_ack_next     = 1'b0;
        rd_ack_next     = 1'b0;
        err_pulse       = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                beat_cnt_next = '0;
                to_cnt_next   = '0;
                if (grant_wr) begin
                    state_next      = ST_WR_BURST;
                    cmd_next        = 1'b1;
                    addr_next       = bus.I_wr_addr;
                    last_grant_next = 1'b1;
                    cmd_en_next     = 1'b1;
                    wr_ack_next     = 1'b1;
                end else if (grant_rd) begin
                    state_next      = ST_RD_WAIT;
                    cmd_next        = 1'b0;
                    addr_next       = bus.I_rd_addr;
                    last_grant_next = 1'b0;
                    cmd_en_next     = 1'b1;
                    rd_ack_next     = 1'b1;
                end
            end

            ST_WR_BURST: begin
                if (!calib) begin
                    state_next = ST_IDLE;
                end else if (beat_cnt_reg == BEAT_W'(BURST - 1)) begin
                    state_next   = ST_GAP;
                    gap_cnt_next = '0;
                end else begin
                    beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                end
            end

            ST_RD_WAIT: begin
                // A beat landing on the timeout cycle still completes the burst cleanly.
                if (!calib) begin
                    state_next = ST_IDLE;
                end else if (rd_last) begin
                    state_next   = ST_GAP;
                    gap_cnt_next = '0;
                end else if (to_expired) begin
                    state_next   = ST_GAP;
                    gap_cnt_next = '0;
                    err_pulse    = 1'b1;
                    if (err_cnt_reg != 8'hFF) begin
                        err_cnt_next = err_cnt_reg + 8'd1;
                    end
                end else begin
                    to_cnt_next = to_cnt_reg + TO_W'(1);
                    if (bus.I_rd_data_valid) begin
                        beat_cnt_next = beat_cnt_reg + BEAT_W'(1);
                    end
                end
            end

            default: begin
                if (!calib || gap_cnt_reg == GAP_W'(CMD_GAP - 1)) begin
                    state_next = ST_IDLE;
                end else begin
                    gap_cnt_next = gap_cnt_reg + GAP_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge I_clk or negedge I_rst_n) begin
        if (!I_rst_n) begin
            state_reg      <= ST_IDLE;
            beat_cnt_reg   <= '0;
            gap_cnt_reg    <= '0;
            to_cnt_reg     <= '0;
            last_grant_reg <= 1'b1;
            cmd_reg        <= 1'b0;
            addr_reg       <= '0;
            cmd_en_reg     <= 1'b0;
            wr_ack_reg     <= 1'b0;
            rd_ack_reg     <= 1'b0;
            err_cnt_reg    <= 8'd0;
        end else begin
            state_reg      <= state_next;
            beat_cnt_reg   <= beat_cnt_next;
            gap_cnt_reg    <= gap_cnt_next;
            to_cnt_reg     <= to_cnt_next;
            last_grant_reg <= last_grant_next;
            cmd_reg        <= cmd_next;
            addr_reg       <= addr_next;
            cmd_en_reg     <= cmd_en_next;
            wr_ack_reg     <= wr_ack_next;
            rd_ack_reg     <= rd_ack_next;
            err_cnt_reg    <= err_cnt_next;
        end
    end

    // Data paths are zero-latency, but forced to zero outside their own burst state.
    logic [DATA_WIDTH-1:0] wr_data_gated;
    logic [DATA_WIDTH-1:0] rd_data_gated;
    logic [MASK_WIDTH-1:0] mask_gated;

    genvar gi;
    generate
        for (gi = 0; gi < DATA_WIDTH; gi++) begin : g_data_bit
            assign wr_data_gated[gi] = wr_phase & bus.I_wr_data[gi];
            assign rd_data_gated[gi] = rd_phase & bus.I_rd_data[gi];
        end
        for (gi = 0; gi < MASK_WIDTH; gi++) begin : g_mask_bit
            assign mask_gated[gi] = wr_phase & bus.I_wr_mask[gi];
        end
    endgenerate

    assign bus.O_cmd_en        = cmd_en_reg;
    assign bus.O_cmd           = cmd_reg;
    assign bus.O_addr          = addr_reg;
    assign bus.O_wr_ack        = wr_ack_reg;
    assign bus.O_rd_ack        = rd_ack_reg;
    assign bus.O_wr_data_rd    = wr_phase;
    assign bus.O_wr_data       = wr_data_gated;
    assign bus.O_data_mask     = mask_gated;
    assign bus.O_rd_data_valid = rd_phase & bus.I_rd_data_valid;
    assign bus.O_rd_data       = rd_data_gated;
    assign bus.O_busy          = (state_reg != ST_IDLE);
    assign bus.O_err           = err_pulse;
    assign bus.O_err_cnt       = err_cnt_reg;

endmodule

// File: tb/tb_hpram_cmd_arbiter.sv
// Directed + randomized bench for hpram_cmd_arbiter: expected grants, beat timing,
// timeouts and error counts come from a transaction-level model of the arbitration rules.
module tb_hpram_cmd_arbiter;
    localparam int AW      = 22;
    localparam int DW      = 32;
    localparam int MW      = DW / 8;
    localparam int BURST   = 16;
    localparam int CMD_GAP = 8;
    localparam int TIMEOUT = 255;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    int   checks   = 0;
    int   failures = 0;
    bit   m_last_wr;    // model: requester granted last (1 = write)
    int   m_err_cnt;    // model: saturating timeout count
    int   n_cmd = 0;

    always #5 clk = ~clk;

    hpram_cmd_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    hpram_cmd_arbiter #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BURST(BURST), .CMD_GAP(CMD_GAP), .TIMEOUT(TIMEOUT)
    ) dut (
        .I_clk   (clk),
        .I_rst_n (rst_n),
        .bus     (bus)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic next_cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_cmd_en"},  bus.O_cmd_en, 0);
        chk({tag, "_cmd"},     bus.O_cmd, 0);
        chk({tag, "_addr"},    bus.O_addr, 0);
        chk({tag, "_wr_ack"},  bus.O_wr_ack, 0);
        chk({tag, "_rd_ack"},  bus.O_rd_ack, 0);
        chk({tag, "_wr_rd"},   bus.O_wr_data_rd, 0);
        chk({tag, "_rd_v"},    bus.O_rd_data_valid, 0);
        chk({tag, "_rd_data"}, bus.O_rd_data, 0);
        chk({tag, "_busy"},    bus.O_busy, 0);
        chk({tag, "_err"},     bus.O_err, 0);
        chk({tag, "_err_cnt"}, bus.O_err_cnt, 0);
    endtask

    // One full command starting from an idle arbiter: request cycle, burst, gap.
    task automatic do_cmd(input bit wreq, input bit rreq, input bit hold, input int rd_beats,
                          input logic [AW-1:0] wa, input logic [AW-1:0] ra);
        bit            win_wr;
        bit            v;
        bit            err_exp;
        bit            done;
        int            beats;
        int            k;
        logic [DW-1:0] d;
        logic [MW-1:0] m;

        next_cyc();
        bus.I_init_calib    = 1'b1;
        bus.I_wr_req        = wreq;
        bus.I_rd_req        = rreq;
        bus.I_wr_addr       = wa;
        bus.I_rd_addr       = ra;
        bus.I_rd_data_valid = 1'($urandom_range(0, 1));
        settle();
        chk("idle_busy", bus.O_busy, 0);
        chk("idle_cmd_en", bus.O_cmd_en, 0);
        chk("idle_rd_valid", bus.O_rd_data_valid, 0);

        win_wr    = (wreq && rreq) ? !m_last_wr : wreq;
        m_last_wr = win_wr;
        beats     = 0;

        if (win_wr) begin
            for (int b = 0; b < BURST; b++) begin
                next_cyc();
                if (b == 0 && !hold) begin
                    bus.I_wr_req = 1'b0;
                    bus.I_rd_req = 1'b0;
                end
                d = DW'($urandom);
                m = MW'($urandom);
                bus.I_wr_data       = d;
                bus.I_wr_mask       = m;
                bus.I_rd_data_valid = 1'($urandom_range(0, 1));
                bus.I_rd_data       = DW'($urandom);
                settle();
                chk("wr_cmd_en", bus.O_cmd_en, b == 0);
                chk("wr_ack", bus.O_wr_ack, b == 0);
                chk("wr_rd_ack", bus.O_rd_ack, 0);
                chk("wr_cmd", bus.O_cmd, 1);
                chk("wr_addr", bus.O_addr, wa);
                chk("wr_data_rd", bus.O_wr_data_rd, 1);
                chk("wr_data", bus.O_wr_data, d);
                chk("wr_mask", bus.O_data_mask, m);
                chk("wr_stray_valid", bus.O_rd_data_valid, 0);
            end
            beats = BURST;
        end else begin
            k    = 0;
            done = 1'b0;
            while (!done) begin
                next_cyc();
                if (k == 0 && !hold) begin
                    bus.I_wr_req = 1'b0;
                    bus.I_rd_req = 1'b0;
                end
                v = (beats < rd_beats) && (($urandom_range(0, 2) != 0) || (k > 150));
                d = DW'($urandom);
                bus.I_rd_data_valid = v;
                bus.I_rd_data       = d;
                bus.I_wr_data       = DW'($urandom);
                settle();
                chk("rd_cmd_en", bus.O_cmd_en, k == 0);
                chk("rd_ack", bus.O_rd_ack, k == 0);
                chk("rd_wr_ack", bus.O_wr_ack, 0);
                chk("rd_cmd", bus.O_cmd, 0);
                chk("rd_addr", bus.O_addr, ra);
                chk("rd_wr_data_rd", bus.O_wr_data_rd, 0);
                chk("rd_valid", bus.O_rd_data_valid, v);
                if (v) begin
                    chk("rd_data", bus.O_rd_data, d);
                    beats++;
                end
                err_exp = (k == TIMEOUT) && (beats < BURST);
                chk("rd_err", bus.O_err, err_exp);
                if (err_exp && m_err_cnt < 255) m_err_cnt++;
                done = (beats == BURST) || (k == TIMEOUT);
                k++;
            end
        end

        for (int g = 0; g < CMD_GAP; g++) begin
            next_cyc();
            bus.I_rd_data_valid = 1'($urandom_range(0, 1));
            settle();
            chk("gap_busy", bus.O_busy, 1);
            chk("gap_cmd_en", bus.O_cmd_en, 0);
            chk("gap_wr_data_rd", bus.O_wr_data_rd, 0);
            chk("gap_rd_valid", bus.O_rd_data_valid, 0);
            chk("gap_err", bus.O_err, 0);
            chk("gap_err_cnt", bus.O_err_cnt, m_err_cnt);
        end
        n_cmd++;
        $display("cmd %0d %s addr=%06h beats=%0d err_cnt=%0d", n_cmd, win_wr ? "WR" : "RD",
                 win_wr ? wa : ra, beats, m_err_cnt);
    endtask

    initial begin
        bus.I_init_calib    = 1'b0;
        bus.I_wr_req        = 1'b0;
        bus.I_wr_addr       = '0;
        bus.I_wr_data       = '0;
        bus.I_wr_mask       = '0;
        bus.I_rd_req        = 1'b0;
        bus.I_rd_addr       = '0;
        bus.I_rd_data_valid = 1'b0;
        bus.I_rd_data       = '0;
        m_last_wr = 1'b1;
        m_err_cnt = 0;

        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        chk_all_zero("reset");
        next_cyc();
        rst_n = 1'b1;

        // Memory not calibrated: both requests pending, nothing may be issued.
        bus.I_wr_req  = 1'b1;
        bus.I_rd_req  = 1'b1;
        bus.I_wr_addr = AW'($urandom);
        bus.I_rd_addr = AW'($urandom);
        for (int i = 0; i < 100; i++) begin
            next_cyc();
            bus.I_rd_data_valid = 1'($urandom_range(0, 1));
            bus.I_rd_data       = DW'($urandom);
            settle();
            chk("nocal_cmd_en", bus.O_cmd_en, 0);
            chk("nocal_busy", bus.O_busy, 0);
            chk("nocal_rd_valid", bus.O_rd_data_valid, 0);
        end

        // Both held: read first, then alternating.
        for (int i = 0; i < 8; i++) begin
            do_cmd(1'b1, 1'b1, 1'b1, BURST, AW'($urandom), AW'($urandom));
        end

        do_cmd(1'b1, 1'b0, 1'b0, BURST, AW'(22'h1234), AW'($urandom));

        for (int i = 0; i < 20; i++) begin
            int sel;
            sel = int'($urandom_range(0, 2));
            do_cmd(sel != 1, sel != 0, 1'b0, BURST, AW'($urandom), AW'($urandom));
        end

        // Calibration lost during beat 5 of a write.
        next_cyc();
        bus.I_init_calib = 1'b1;
        bus.I_wr_req     = 1'b1;
        bus.I_rd_req     = 1'b0;
        bus.I_wr_addr    = AW'($urandom);
        settle();
        chk("cd_idle_busy", bus.O_busy, 0);
        m_last_wr = 1'b1;
        for (int b = 0; b < 6; b++) begin
            next_cyc();
            if (b == 5) bus.I_init_calib = 1'b0;
            bus.I_wr_data = DW'($urandom);
            settle();
            chk("cd_cmd_en", bus.O_cmd_en, b == 0);
            chk("cd_wr_data_rd", bus.O_wr_data_rd, 1);
        end
        for (int i = 0; i < 20; i++) begin
            next_cyc();
            bus.I_rd_data_valid = 1'($urandom_range(0, 1));
            settle();
            chk("cd_busy", bus.O_busy, 0);
            chk("cd_wr_data_rd_off", bus.O_wr_data_rd, 0);
            chk("cd_no_ack", bus.O_wr_ack, 0);
            chk("cd_no_cmd_en", bus.O_cmd_en, 0);
            chk("cd_rd_valid", bus.O_rd_data_valid, 0);
        end
        do_cmd(1'b1, 1'b0, 1'b0, BURST, AW'($urandom), AW'($urandom));

        // Read that only gets 10 beats back.
        do_cmd(1'b0, 1'b1, 1'b0, 10, AW'($urandom), AW'($urandom));
        next_cyc();
        settle();
        chk("timeout_err_cnt", bus.O_err_cnt, 1);
        chk("timeout_idle", bus.O_busy, 0);

        // Asynchronous reset in the middle of a read burst.
        next_cyc();
        bus.I_init_calib = 1'b1;
        bus.I_rd_req     = 1'b1;
        bus.I_wr_req     = 1'b0;
        bus.I_rd_addr    = AW'(22'h2AAAA);
        settle();
        chk("ar_idle_busy", bus.O_busy, 0);
        for (int b = 0; b < 4; b++) begin
            next_cyc();
            bus.I_rd_req        = 1'b0;
            bus.I_rd_data_valid = 1'b1;
            bus.I_rd_data       = DW'($urandom);
            settle();
            chk("ar_pre_busy", bus.O_busy, 1);
            chk("ar_pre_valid", bus.O_rd_data_valid, 1);
        end
        #1 rst_n = 1'b0;
        #1;
        chk_all_zero("async_rst");
        next_cyc();
        next_cyc();
        rst_n = 1'b1;
        bus.I_rd_data_valid = 1'b0;
        m_last_wr = 1'b1;
        m_err_cnt = 0;
        do_cmd(1'b1, 1'b1, 1'b0, BURST, AW'($urandom), AW'($urandom));

        // Enough lost bursts to drive the error counter into saturation.
        for (int i = 0; i < 257; i++) begin
            do_cmd(1'b0, 1'b1, 1'b0, 0, AW'($urandom), AW'($urandom));
        end
        next_cyc();
        settle();
        chk("err_cnt_sat", bus.O_err_cnt, 255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
